// File: rtl/sisc_fetch.sv
// SISC instruction fetch: PC, variable-latency memory read, valid/ready issue of ir to the core.
// Optional fetch timeout (sticky fetch_err, halts fetching) when SISC_FETCH_TIMEOUT_EN is defined.
module sisc_fetch #(
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OP     = 4'hF,
  parameter int unsigned       TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic              halt,
  output logic              fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALTED} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt, mem_addr_nxt;
  logic [31:0]       ir_nxt;
  logic              mem_rd_nxt, ir_valid_nxt, halt_nxt;
  logic              timeout;

`ifdef SISC_FETCH_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] to_cnt;
  logic          fetch_err_q;

  // An ack on the terminal count still wins: timeout only fires without ack.
  assign timeout = (state == REQ) && !mem_ack && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      to_cnt      <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      if (state != REQ)
        to_cnt <= '0;
      else if (!mem_ack)
        to_cnt <= to_cnt + 1'b1;
      if (timeout)
        fetch_err_q <= 1'b1;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      ir       <= 32'h0;
      ir_valid <= 1'b0;
      halt     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      mem_rd   <= mem_rd_nxt;
      mem_addr <= mem_addr_nxt;
      ir       <= ir_nxt;
      ir_valid <= ir_valid_nxt;
      halt     <= halt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    mem_rd_nxt   = mem_rd;
    mem_addr_nxt = mem_addr;
    ir_nxt       = ir;
    ir_valid_nxt = ir_valid;
    halt_nxt     = halt;
    case (state)
      IDLE: begin
        mem_rd_nxt   = 1'b1;
        mem_addr_nxt = pc;
        state_nxt    = REQ;
      end
      REQ: begin
        if (mem_ack) begin
          ir_nxt       = mem_rdata;
          ir_valid_nxt = 1'b1;
          mem_rd_nxt   = 1'b0;
          pc_nxt       = pc + 1'b1;
          state_nxt    = ISSUE;
        end else if (timeout) begin
          mem_rd_nxt = 1'b0;
          halt_nxt   = 1'b1;
          state_nxt  = HALTED;
        end
      end
      ISSUE: begin
        if (ir_ready) begin
          ir_valid_nxt = 1'b0;
          // A HALT is final: any redirect offered alongside it is dropped.
          if (ir[31:28] == HALT_OP) begin
            halt_nxt  = 1'b1;
            state_nxt = HALTED;
          end else begin
            pc_nxt       = br_taken ? br_target : pc;
            mem_rd_nxt   = 1'b1;
            mem_addr_nxt = pc_nxt;
            state_nxt    = REQ;
          end
        end
      end
      HALTED: begin
        mem_rd_nxt   = 1'b0;
        ir_valid_nxt = 1'b0;
        halt_nxt     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sisc_fetch.sv
// Randomized scoreboard bench for sisc_fetch; the model tracks the architectural fetch stream.
module tb_sisc_fetch;
  localparam int              AW  = 16;
  localparam logic [AW-1:0]   RPC = '0;
  localparam int              TO  = 8;

  logic          clk = 1'b0;
  logic          rst_f = 1'b0;
  logic          mem_rd, ir_valid, halt, fetch_err;
  logic          mem_ack = 1'b0, ir_ready = 1'b0, br_taken = 1'b0;
  logic [AW-1:0] mem_addr, pc;
  logic [AW-1:0] br_target = '0;
  logic [31:0]   mem_rdata = '0;
  logic [31:0]   ir;

  always #5 clk = ~clk;

  sisc_fetch #(.ADDR_W(AW), .RESET_PC(RPC), .HALT_OP(4'hF), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_f(rst_f), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_taken(br_taken), .br_target(br_target), .pc(pc), .halt(halt), .fetch_err(fetch_err)
  );

  int n_cmp = 0, n_err = 0, n_issued = 0;
  logic [AW-1:0] addr_q[$];
  logic [31:0]   ir_q[$];
  logic [31:0]   mem [0:255];
  bit            exp_halt = 0, exp_err = 0, hold_chk = 0, pending_halt = 0, rst_prev = 0;
  bit            no_ack = 0, stray = 0;
  logic [AW-1:0] exp_halt_pc = '0, pend_halt_pc = '0, cur_fetch = '0, last_ack = '0;
  int            lat_fix = 0, lat_left = -1, rdy_mode = 0, br_mode = 0, vld_cnt = 0, req_seen = 0;

  // Instruction memory image: low 256 words from an array, the rest a fixed non-HALT pattern.
  function automatic logic [31:0] word(input logic [AW-1:0] a);
    if (a < 256) return mem[a[7:0]];
    return {4'(1 + a % 14), 12'h5A5, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [AW-1:0] a);
    addr_q.push_back(a);
    ir_q.push_back(word(a));
    cur_fetch = a;
  endtask

  task automatic do_reset(input int n, input bit late_ack);
    rst_f = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0; br_taken = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    addr_q.delete(); ir_q.delete();
    exp_halt = 0; exp_err = 0; pending_halt = 0; hold_chk = 0;
    no_ack = 0; req_seen = 0; lat_left = -1; vld_cnt = 0;
    push_fetch(RPC);
    rst_f = 1'b1;
    mem_ack = late_ack;
    mem_rdata = $urandom;
  endtask

  task automatic cycle();
    logic [31:0] w;
    @(posedge clk); #1;
    if (pending_halt) begin
      exp_halt = 1; exp_halt_pc = pend_halt_pc; pending_halt = 0;
    end
`ifdef SISC_FETCH_TIMEOUT_EN
    if (no_ack && req_seen == TO && !exp_halt) begin
      exp_halt = 1; exp_err = 1; exp_halt_pc = cur_fetch;
    end
`endif
    mem_rdata = $urandom;
    mem_ack = 1'b0;
    if (mem_rd) begin
      if (no_ack) req_seen++;
      else begin
        if (lat_left < 0) lat_left = (lat_fix < 0) ? $urandom_range(0, 7) : lat_fix;
        if (lat_left == 0) begin
          mem_ack = 1'b1; mem_rdata = word(mem_addr); lat_left = -1;
        end else lat_left--;
      end
    end else if (stray) mem_ack = ($urandom_range(0, 3) == 0);
    hold_chk = no_ack && (req_seen > 0);

    if (ir_valid) vld_cnt++; else vld_cnt = 0;
    case (rdy_mode)
      0:       ir_ready = 1'b1;
      1:       ir_ready = 1'($urandom_range(0, 1));
      default: ir_ready = (vld_cnt > 4);
    endcase
    br_target = AW'($urandom);
    br_taken  = (br_mode == 2) && ($urandom_range(0, 3) == 0);
    if (br_mode == 2 && $urandom_range(0, 15) == 0) br_target = '1;
    else if (br_mode == 2 && $urandom_range(0, 3) == 0) br_target = AW'($urandom_range(0, 255));
    if (ir_valid && ir_ready) begin
      if (br_mode == 1 && cur_fetch == 5) begin br_taken = 1'b1; br_target = 16'h0040; end
      w = word(cur_fetch);
      if (w[31:28] == 4'hF) begin
        pending_halt = 1; pend_halt_pc = cur_fetch + 1'b1;
      end else begin
        n_issued++;
        push_fetch(br_taken ? br_target : cur_fetch + 1'b1);
      end
    end
  endtask

  always @(posedge clk) rst_prev <= rst_f;

  always @(negedge clk) begin
    logic [AW-1:0] nx;
    if (!rst_prev) begin
      chk("rst_mem_rd", 64'(mem_rd), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_ir", 64'(ir), 64'd0);
      chk("rst_ir_valid", 64'(ir_valid), 64'd0);
      chk("rst_pc", 64'(pc), 64'(RPC));
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_fetch_err", 64'(fetch_err), 64'd0);
    end else begin
      chk("halt", 64'(halt), 64'(exp_halt));
      chk("fetch_err", 64'(fetch_err), 64'(exp_err));
      if (exp_halt) begin
        chk("halted_mem_rd", 64'(mem_rd), 64'd0);
        chk("halted_ir_valid", 64'(ir_valid), 64'd0);
        chk("halted_pc", 64'(pc), 64'(exp_halt_pc));
      end else begin
        if (hold_chk) chk("hold_mem_rd", 64'(mem_rd), 64'd1);
        if (addr_q.size() == 0) chk("mem_rd_unexpected", 64'(mem_rd), 64'd0);
        else if (mem_rd) begin
          chk("mem_addr", 64'(mem_addr), 64'(addr_q[0]));
          chk("pc_in_req", 64'(pc), 64'(addr_q[0]));
          if (mem_ack) last_ack = addr_q.pop_front();
        end
        if (ir_q.size() == 0) chk("ir_valid_unexpected", 64'(ir_valid), 64'd0);
        else if (ir_valid) begin
          chk("ir", 64'(ir), 64'(ir_q[0]));
          nx = last_ack + 1'b1;
          chk("pc_in_issue", 64'(pc), 64'(nx));
          if (ir_ready) void'(ir_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] save;
    for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(0, 14)), 28'($urandom)};
    mem[0] = 32'h10120000;
    mem[1] = 32'h20230000;

    // back-to-back fetch, single-cycle ack, core always ready
    lat_fix = 0; rdy_mode = 0; br_mode = 0; stray = 0;
    do_reset(3, 0);
    repeat (8) cycle();

    // slow memory and a core that stalls four cycles per instruction
    lat_fix = 3; rdy_mode = 2;
    do_reset(2, 0);
    repeat (40) cycle();

    // redirect to 0x0040 when the word from address 5 issues
    lat_fix = 0; rdy_mode = 0; br_mode = 1;
    do_reset(2, 0);
    repeat (24) cycle();

    // HALT at address 3, then reset out of HALTED
    br_mode = 0; save = mem[3]; mem[3] = 32'hF0000000;
    do_reset(2, 0);
    repeat (30) cycle();
    do_reset(2, 0);
    mem[3] = save;
    repeat (6) cycle();

    // reset while a request is outstanding, ack arrives just after reset
    lat_fix = 5;
    do_reset(2, 0);
    repeat (3) cycle();
    do_reset(1, 1);
    lat_fix = 0;
    repeat (10) cycle();

    // memory never answers
    do_reset(2, 0);
    no_ack = 1;
    repeat (14) cycle();

    // random latency, readiness, redirects and stray acks, with a HALT planted
    for (int r = 0; r < 6; r++) begin
      lat_fix = -1; rdy_mode = 1; br_mode = 2; stray = 1;
      mem[200 + r] = {4'hF, 28'($urandom)};
      do_reset(1 + r % 3, 0);
      repeat (500) cycle();
    end
    do_reset(2, 0);
    repeat (2) cycle();

    chk("issued_count_min", 64'(n_issued > 50), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sisc_fetch.md
Name: sisc_fetch

Overview:
Instruction fetch unit for the SISC core; the producer end of the core's 32-bit ir input.
- Holds the program counter and reads instruction words from a variable-latency instruction memory.
- Presents each word to the core with a valid/ready handshake.
- Applies branch redirects from the core and stops fetching after a HALT opcode.

Parameters:
ADDR_W, 16, PC/memory word-address width; PC wraps modulo 2^ADDR_W
RESET_PC, 0, PC value loaded on reset
HALT_OP, 4'hF, opcode (ir[31:28]) that stops fetching
TIMEOUT_CYC, 64, max REQ cycles before fetch error (used only with the optional feature)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_f  in  1  synchronous active-low reset, sampled on rising clk
mem_rd  out  1  read request, registered
mem_addr  out  ADDR_W  word address of request, registered, equals pc while mem_rd=1
mem_rdata  in  32  instruction word, valid when mem_ack=1
mem_ack  in  1  memory completes request this cycle; ignored when mem_rd=0
ir  out  32  instruction to core, registered
ir_valid  out  1  ir holds an unconsumed instruction
ir_ready  in  1  core accepts ir this cycle
br_taken  in  1  core redirect, qualified by ir_valid&ir_ready
br_target  in  ADDR_W  redirect address
pc  out  ADDR_W  address of next fetch
halt  out  1  HALT fetched and issued; sticky until reset
fetch_err  out  1  fetch timeout, sticky; tied 0 without SISC_FETCH_TIMEOUT_EN

Behaviour:
- Reset (rst_f=0 at posedge):
  - state=IDLE, pc=RESET_PC, mem_rd=0, mem_addr=0, ir=32'h0, ir_valid=0, halt=0, fetch_err=0, timeout counter=0.
  - Reset has priority over every other event. Mid-operation it abandons any outstanding request; a late mem_ack is ignored because mem_rd=0.
- States: IDLE, REQ, ISSUE, HALTED.
- IDLE: next cycle mem_rd<=1, mem_addr<=pc, go to REQ.
- REQ: mem_rd held 1 and mem_addr stable until mem_ack.
  - On mem_ack: ir<=mem_rdata, ir_valid<=1, mem_rd<=0, pc<=pc+1 (wrapping all-ones -> 0), go to ISSUE.
- ISSUE: ir and ir_valid held stable while ir_ready=0. On ir_ready=1:
  - ir_valid<=0.
  - If br_taken=1: pc<=br_target, else pc unchanged.
  - If ir[31:28]==HALT_OP: halt<=1, go to HALTED. br_taken is ignored, pc keeps the post-HALT value.
  - Else: mem_rd<=1, mem_addr<=(br_taken ? br_target : pc), go to REQ.
- br_taken/br_target are ignored unless state=ISSUE and ir_ready=1.
- HALTED: mem_rd=0, ir_valid=0, halt=1. Exit only via reset.
- Latency:
  - Reset release -> mem_rd high: 1 cycle.
  - mem_ack at cycle N -> ir_valid at N+1.
  - ir_ready at cycle N -> next mem_rd at N+1.
  - Minimum issue interval: 2 cycles with single-cycle ack (ack in first REQ cycle).
- Redirect: the fetched-but-unissued instruction is the one being accepted, so no instruction is discarded. The core evaluates branches on the issued ir.
- Simultaneous: mem_ack outside REQ is ignored. ir_ready while ir_valid=0 is ignored.

Optional Feature:
Macro SISC_FETCH_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle in REQ without mem_ack and clears on entry to REQ.
  - When it reaches TIMEOUT_CYC-1 without ack: mem_rd<=0, fetch_err<=1, halt<=1, go to HALTED.
  - mem_ack in the same cycle as the terminal count wins (normal capture).
- Undefined: no counter; REQ waits indefinitely; fetch_err constant 0.

Test Plan:
- Reset, memory returns ack 1 cycle after each mem_rd with words 0x10120000, 0x20230000, ir_ready always 1 -> mem_addr 0,1,2; ir 0x10120000 then 0x20230000; pc=2 after second issue; ir_valid high one cycle each.
- Memory ack delayed 3 cycles; core ir_ready low 4 cycles after ir_valid -> mem_addr stable during wait, ir stable and ir_valid held until ready, no second mem_rd until the cycle after ir_ready.
- At pc=5, issue word with br_taken=1, br_target=0x0040 -> next mem_addr=0x0040, pc=0x0041 after fetch.
- Word 0xF0000000 fetched at addr 3, accepted -> halt=1, mem_rd stays 0 for 20 cycles, pc=4. rst_f=0 -> halt=0, pc=RESET_PC.
- rst_f pulsed low while in REQ with ack arriving the cycle after reset -> ack ignored, ir=0, ir_valid=0, fresh mem_rd at addr RESET_PC.
- With SISC_FETCH_TIMEOUT_EN, TIMEOUT_CYC=8, no ack -> after 8 REQ cycles mem_rd=0, fetch_err=1, halt=1. Without macro, same stimulus -> mem_rd stays 1, fetch_err=0.
